// File: rtl/oam_dma_if.sv
// CPU-side and memory-map-side bus bundle around the OAM DMA engine.
// The slave modport is the DMA engine's view; master is the surrounding system.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_wren;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic [7:0]  mem_q;
  logic [15:0] mem_addr;
  logic        mem_wren;
  logic [7:0]  mem_data;
  logic        dma_active;

  modport master (
    output cpu_addr, cpu_wren, cpu_data_in, mem_q,
    input  cpu_data_out, mem_addr, mem_wren, mem_data, dma_active
  );

  modport slave (
    input  cpu_addr, cpu_wren, cpu_data_in, mem_q,
    output cpu_data_out, mem_addr, mem_wren, mem_data, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies 160 bytes from {src_hi,00} to 0xFE00 as alternating READ/WRITE cycles,
// passing the CPU straight through to the memory map while idle.
module oam_dma (
  input  logic      clock,
  input  logic      reset_n,
  oam_dma_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  LAST_IDX     = 8'd159;
  localparam logic [7:0]  OAM_HI       = 8'hFE;

  state_t     state_r;
  logic [7:0] idx_r;
  logic [7:0] src_hi_r;
  logic [7:0] eff_hi_s;
  logic       reg_sel_s;
  logic       dma_wr_s;

  // Echo RAM (0xE000-0xFFFF) folds back onto work RAM at 0xC000-0xDFFF.
  function automatic logic [7:0] fold_echo(input logic [7:0] hi);
    if (hi >= 8'hE0) begin
      return hi - 8'h20;
    end else begin
      return hi;
    end
  endfunction

  // Register decode and source page selection.
  always_comb begin
    reg_sel_s = (bus.cpu_addr == DMA_REG_ADDR);
    dma_wr_s  = bus.cpu_wren && reg_sel_s;
    eff_hi_s  = fold_echo(src_hi_r);
  end

  // Transfer sequencer; a register write restarts from byte 0 in any state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      idx_r    <= 8'd0;
      src_hi_r <= 8'hFF;
    end else if (dma_wr_s) begin
      src_hi_r <= bus.cpu_data_in;
      state_r  <= READ;
      idx_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        READ: begin
          state_r <= WRITE;
        end
        WRITE: begin
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            idx_r   <= 8'd0;
          end else begin
            state_r <= READ;
            idx_r   <= idx_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= 8'd0;
        end
      endcase
    end
  end

  // Bus ownership: the DMA drives the memory map in READ/WRITE, the CPU otherwise.
  always_comb begin
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wren   = bus.cpu_wren;
    bus.mem_data   = bus.cpu_data_in;
    bus.dma_active = 1'b0;
    case (state_r)
      IDLE: begin
        bus.dma_active = 1'b0;
      end
      READ: begin
        bus.mem_addr   = {eff_hi_s, idx_r};
        bus.mem_wren   = 1'b0;
        bus.mem_data   = 8'h00;
        bus.dma_active = 1'b1;
      end
      WRITE: begin
        bus.mem_addr   = {OAM_HI, idx_r};
        bus.mem_wren   = 1'b1;
        bus.mem_data   = bus.mem_q;
        bus.dma_active = 1'b1;
      end
      default: begin
        bus.dma_active = 1'b0;
      end
    endcase
  end

  // CPU read-back; the rest of the map reads as open bus while a transfer runs.
  always_comb begin
    if (reg_sel_s) begin
      bus.cpu_data_out = src_hi_r;
    end else if (state_r == IDLE) begin
      bus.cpu_data_out = bus.mem_q;
    end else begin
      bus.cpu_data_out = 8'hFF;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a synchronous 64K memory map model around the DMA,
// with one task per scenario and hand-derived expected values.
module tb_oam_dma;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  oam_dma_if bus ();

  oam_dma dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory map: written bytes override a fixed per-page source pattern.
  bit [7:0] mem_w [0:65535];
  bit       mem_v [0:65535];

  function automatic logic [7:0] pattern(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hC1:   return a[7:0] + 8'h03;
      8'hD0:   return a[7:0] ^ 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem_v[a]) return mem_w[a];
    else return pattern(a);
  endfunction

  always @(posedge clock) begin
    bus.mem_q <= mem_rd(bus.mem_addr);
    if (bus.mem_wren) begin
      mem_w[bus.mem_addr] <= bus.mem_data;
      mem_v[bus.mem_addr] <= 1'b1;
    end
  end

  task automatic set_cpu(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus.cpu_addr    = a;
    bus.cpu_wren    = w;
    bus.cpu_data_in = d;
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Entered on the first READ cycle; returns at the first IDLE cycle (or after 400 cycles).
  task automatic run_transfer(input logic [7:0] exp_hi, output int cycles, output int seq_err);
    logic [15:0] exp_addr;
    cycles  = 0;
    seq_err = 0;
    while (bus.dma_active && cycles < 400) begin
      if (cycles[0] == 1'b0) exp_addr = {exp_hi, 8'(cycles / 2)};
      else exp_addr = 16'hFE00 + 16'(cycles / 2);
      if (bus.mem_addr !== exp_addr || bus.mem_wren !== cycles[0]) seq_err++;
      if (bus.cpu_addr != 16'hFF46 && bus.cpu_data_out !== 8'hFF) seq_err++;
      cycles++;
      @(negedge clock);
      #1;
    end
  endtask

  function automatic int oam_bad(input logic [15:0] src_base);
    int n;
    n = 0;
    for (int k = 0; k < 160; k++) begin
      if (mem_rd(16'hFE00 + 16'(k)) !== pattern(src_base + 16'(k))) n++;
    end
    return n;
  endfunction

  task automatic test_reset;
    @(negedge clock);
    reset_n = 1'b0;
    set_cpu(16'hFF46, 1'b1, 8'h12);
    @(negedge clock);
    reset_n = 1'b1;
    set_cpu(16'hFF46, 1'b0, 8'h00);
    #1;
    total++; if (bus.dma_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0h exp=0", bus.dma_active); end
    total++; if (bus.cpu_data_out !== 8'hFF) begin bad++; $display("FAIL reset_src_hi got=%0h exp=ff", bus.cpu_data_out); end
    total++; if (bus.mem_addr !== 16'hFF46) begin bad++; $display("FAIL reset_pass_addr got=%0h exp=ff46", bus.mem_addr); end
    total++; if (bus.mem_wren !== 1'b0) begin bad++; $display("FAIL reset_pass_wren got=%0h exp=0", bus.mem_wren); end
    step(1);
    total++; if (bus.dma_active !== 1'b0) begin bad++; $display("FAIL reset_write_ignored got=%0h exp=0", bus.dma_active); end
  endtask

  task automatic test_passthrough;
    @(negedge clock);
    set_cpu(16'hFF80, 1'b1, 8'h3C);
    #1;
    total++; if (bus.mem_addr !== 16'hFF80 || bus.mem_wren !== 1'b1 || bus.mem_data !== 8'h3C) begin
      bad++; $display("FAIL pass_write got=%0h/%0h/%0h exp=ff80/1/3c", bus.mem_addr, bus.mem_wren, bus.mem_data);
    end
    @(negedge clock);
    set_cpu(16'hFF80, 1'b0, 8'h00);
    step(1);
    total++; if (bus.cpu_data_out !== 8'h3C) begin bad++; $display("FAIL pass_read got=%0h exp=3c", bus.cpu_data_out); end
  endtask

  task automatic test_full_transfer;
    int cyc, serr, nbad;
    @(negedge clock);
    set_cpu(16'hFF46, 1'b1, 8'hC0);
    #1;
    total++; if (bus.dma_active !== 1'b0) begin bad++; $display("FAIL full_idle_on_write got=%0h exp=0", bus.dma_active); end
    @(negedge clock);
    set_cpu(16'h0000, 1'b0, 8'h00);
    #1;
    total++; if (bus.mem_addr !== 16'hC000 || bus.dma_active !== 1'b1) begin
      bad++; $display("FAIL full_first_read got=%0h/%0h exp=c000/1", bus.mem_addr, bus.dma_active);
    end
    run_transfer(8'hC0, cyc, serr);
    total++; if (cyc !== 320) begin bad++; $display("FAIL full_cycles got=%0d exp=320", cyc); end
    total++; if (serr !== 0) begin bad++; $display("FAIL full_sequence got=%0d errors exp=0", serr); end
    total++; if (bus.dma_active !== 1'b0) begin bad++; $display("FAIL full_idle_after got=%0h exp=0", bus.dma_active); end
    nbad = oam_bad(16'hC000);
    total++; if (nbad !== 0) begin bad++; $display("FAIL full_oam got=%0d bad bytes exp=0", nbad); end
    set_cpu(16'hFF46, 1'b0, 8'h00);
    #1;
    total++; if (bus.cpu_data_out !== 8'hC0) begin bad++; $display("FAIL full_src_read got=%0h exp=c0", bus.cpu_data_out); end
  endtask

  task automatic test_echo_and_blocked_cpu;
    int cyc, serr, nbad;
    @(negedge clock);
    set_cpu(16'hFF46, 1'b1, 8'hE1);
    @(negedge clock);
    set_cpu(16'hFF46, 1'b0, 8'h00);
    #1;
    total++; if (bus.cpu_data_out !== 8'hE1) begin bad++; $display("FAIL echo_src_read got=%0h exp=e1", bus.cpu_data_out); end
    total++; if (bus.mem_addr !== 16'hC100) begin bad++; $display("FAIL echo_first_read got=%0h exp=c100", bus.mem_addr); end
    set_cpu(16'hC123, 1'b1, 8'h77);
    #1;
    run_transfer(8'hC1, cyc, serr);
    set_cpu(16'h0000, 1'b0, 8'h00);
    total++; if (cyc !== 320) begin bad++; $display("FAIL echo_cycles got=%0d exp=320", cyc); end
    total++; if (serr !== 0) begin bad++; $display("FAIL echo_sequence got=%0d errors exp=0", serr); end
    total++; if (mem_rd(16'hC123) !== 8'h26) begin bad++; $display("FAIL blocked_write got=%0h exp=26", mem_rd(16'hC123)); end
    nbad = oam_bad(16'hC100);
    total++; if (nbad !== 0) begin bad++; $display("FAIL echo_oam got=%0d bad bytes exp=0", nbad); end
  endtask

  task automatic test_restart;
    int cyc, serr, nbad;
    @(negedge clock);
    set_cpu(16'hFF46, 1'b1, 8'hC0);
    @(negedge clock);
    set_cpu(16'hC000, 1'b0, 8'h00);
    #1;
    total++; if (bus.cpu_data_out !== 8'hFF) begin bad++; $display("FAIL restart_open_bus got=%0h exp=ff", bus.cpu_data_out); end
    step(160);
    total++; if (bus.mem_addr !== 16'hC050 || bus.mem_wren !== 1'b0) begin
      bad++; $display("FAIL restart_at_i80 got=%0h/%0h exp=c050/0", bus.mem_addr, bus.mem_wren);
    end
    set_cpu(16'hFF46, 1'b1, 8'hD0);
    @(negedge clock);
    set_cpu(16'hC000, 1'b0, 8'h00);
    #1;
    total++; if (bus.mem_addr !== 16'hD000) begin bad++; $display("FAIL restart_first_read got=%0h exp=d000", bus.mem_addr); end
    run_transfer(8'hD0, cyc, serr);
    total++; if (cyc !== 320) begin bad++; $display("FAIL restart_cycles got=%0d exp=320", cyc); end
    total++; if (serr !== 0) begin bad++; $display("FAIL restart_sequence got=%0d errors exp=0", serr); end
    nbad = oam_bad(16'hD000);
    total++; if (nbad !== 0) begin bad++; $display("FAIL restart_oam got=%0d bad bytes exp=0", nbad); end
  endtask

  task automatic test_reset_abort;
    @(negedge clock);
    set_cpu(16'hFF46, 1'b1, 8'hE1);
    @(negedge clock);
    set_cpu(16'h0000, 1'b0, 8'h00);
    step(81);
    total++; if (bus.mem_addr !== 16'hFE28 || bus.mem_wren !== 1'b1) begin
      bad++; $display("FAIL abort_at_i40 got=%0h/%0h exp=fe28/1", bus.mem_addr, bus.mem_wren);
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    set_cpu(16'hFF46, 1'b0, 8'h00);
    #1;
    total++; if (bus.dma_active !== 1'b0) begin bad++; $display("FAIL abort_active got=%0h exp=0", bus.dma_active); end
    total++; if (bus.cpu_data_out !== 8'hFF) begin bad++; $display("FAIL abort_src_hi got=%0h exp=ff", bus.cpu_data_out); end
    set_cpu(16'h0000, 1'b0, 8'h00);
    step(3);
    total++; if (mem_rd(16'hFE28) !== 8'h2B) begin bad++; $display("FAIL abort_last_written got=%0h exp=2b", mem_rd(16'hFE28)); end
    total++; if (mem_rd(16'hFE29) !== 8'h8C) begin bad++; $display("FAIL abort_fe29_kept got=%0h exp=8c", mem_rd(16'hFE29)); end
    total++; if (mem_rd(16'hFE9F) !== 8'h3A) begin bad++; $display("FAIL abort_fe9f_kept got=%0h exp=3a", mem_rd(16'hFE9F)); end
  endtask

  task automatic test_back_to_back;
    int cyc, serr;
    @(negedge clock);
    set_cpu(16'hFF46, 1'b1, 8'hC0);
    @(negedge clock);
    set_cpu(16'h0000, 1'b0, 8'h00);
    step(319);
    total++; if (bus.mem_addr !== 16'hFE9F || bus.mem_wren !== 1'b1) begin
      bad++; $display("FAIL b2b_last_write got=%0h/%0h exp=fe9f/1", bus.mem_addr, bus.mem_wren);
    end
    set_cpu(16'hFF46, 1'b1, 8'hE1);
    @(negedge clock);
    set_cpu(16'h0000, 1'b0, 8'h00);
    #1;
    total++; if (bus.dma_active !== 1'b1 || bus.mem_addr !== 16'hC100) begin
      bad++; $display("FAIL b2b_restart got=%0h/%0h exp=1/c100", bus.dma_active, bus.mem_addr);
    end
    run_transfer(8'hC1, cyc, serr);
    total++; if (cyc !== 320) begin bad++; $display("FAIL b2b_cycles got=%0d exp=320", cyc); end
    total++; if (serr !== 0) begin bad++; $display("FAIL b2b_sequence got=%0d errors exp=0", serr); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    set_cpu(16'h0000, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    test_reset;
    test_passthrough;
    test_full_transfer;
    test_echo_and_blocked_cpu;
    test_restart;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-003 SHALL have port: cpu_addr  in  16  CPU bus address.
REQ-004 SHALL have port: cpu_wren  in  1  CPU write strobe.
REQ-005 SHALL have port: cpu_data_in  in  8  CPU write data.
REQ-006 SHALL have port: mem_q  in  8  read data from the memory map; valid one cycle after its address is presented (synchronous RAM/ROM).
REQ-007 SHALL have port: mem_addr  out  16  address driven to the memory map.
REQ-008 SHALL have port: mem_wren  out  1  write strobe driven to the memory map.
REQ-009 SHALL have port: mem_data  out  8  write data driven to the memory map.
REQ-010 SHALL have port: cpu_data_out  out  8  read data returned to the CPU.
REQ-011 SHALL have port: dma_active  out  1  high while a transfer owns the memory bus; the top level uses it to hold PPU OAM reads off.

Function
REQ-012 SHALL hold register DMA (address 0xFF46): 8-bit source high byte src_hi.
REQ-013 SHALL load src_hi from cpu_data_in on any cycle with cpu_wren=1 and cpu_addr=0xFF46, in any state; this is the only CPU write honoured during a transfer.
REQ-014 SHALL, on a DMA write, enter READ with byte index i=0 on the next cycle; a write during an active transfer restarts it at i=0 with the new src_hi.
REQ-015 SHALL implement FSM states IDLE, READ, WRITE; IDLE->READ on DMA write; READ->WRITE always; WRITE->READ with i+1 if i<159; WRITE->IDLE if i=159.
REQ-016 SHALL, in READ, drive mem_addr={eff_hi, i}, mem_wren=0.
REQ-017 SHALL, in WRITE, drive mem_addr=0xFE00+i, mem_wren=1, mem_data=mem_q.
REQ-018 SHALL compute eff_hi = src_hi-0x20 when src_hi is 0xE0..0xFF, else src_hi.
REQ-019 SHALL keep i as an 8-bit counter with range 0..159; it never reaches 160.
REQ-020 SHALL complete a full transfer in exactly 320 cycles from the first READ cycle to the return to IDLE.
REQ-021 SHALL assert dma_active combinationally in READ and WRITE; deassert it in IDLE.
REQ-022 SHALL, in IDLE, pass the CPU through: mem_addr=cpu_addr, mem_wren=cpu_wren, mem_data=cpu_data_in.
REQ-023 SHALL drive cpu_data_out=src_hi when cpu_addr=0xFF46, in any state.
REQ-024 SHALL otherwise drive cpu_data_out=mem_q in IDLE and 0xFF in READ/WRITE.
REQ-025 SHALL drop CPU writes to addresses other than 0xFF46 during a transfer; they never reach mem_wren.
REQ-026 SHALL give a DMA write priority over FSM advance when both occur in the same cycle, including the cycle WRITE i=159.

Reset
REQ-027 SHALL, with reset_n=0 at a rising edge, set state=IDLE, i=0, src_hi=0xFF.
REQ-028 SHALL hold outputs after reset at dma_active=0 with pass-through per REQ-022.
REQ-029 SHALL abort a transfer immediately on reset mid-transfer; no further mem_wren from the DMA; already-written OAM bytes are left as written.
REQ-030 SHALL ignore a DMA write in the same cycle as reset_n=0.

Verification
REQ-031 SHALL cover: preload 0xC000..0xC09F with value k^0x5A; CPU writes 0x C0 to 0xFF46 -> 320 cycles of dma_active, OAM 0xFE00+k = k^0x5A for all k, dma_active=0 at cycle 321.
REQ-032 SHALL cover: write 0xE1 to 0xFF46 -> READ addresses 0xC100..0xC19F; read of 0xFF46 returns 0xE1.
REQ-033 SHALL cover: during a transfer, CPU write 0x77 to 0xC123 and read of 0xC000 -> mem_wren never high at 0xC123, cpu_data_out=0xFF.
REQ-034 SHALL cover: at i=80, write 0xD0 to 0xFF46 -> next cycle READ at 0xD000; 320 further cycles to IDLE; OAM holds 0xD000.. data.
REQ-035 SHALL cover: reset_n=0 at i=40 (WRITE) -> next cycle IDLE, dma_active=0, src_hi=0xFF, OAM 0xFE29 onward unchanged.
REQ-036 SHALL cover: after reset, with no DMA write, CPU read/write of 0xFF80 -> pass-through; cpu_data_out=mem_q one cycle later.
